// File: rtl/patch_sched_pkg.sv
// Shared constants, FSM state encoding and patch-role encodings for the
// three-patch time-step scheduler.
package patch_sched_pkg;

   localparam int DATA_W     = 18;
   localparam int PATCH_SIZE = 16;
   localparam int ADDR_W     = 4;
   localparam int NUM_PATCH  = 3;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_RD_CUR   = 4'd1,
      S_RD_PREV  = 4'd2,
      S_CAP_CUR  = 4'd3,
      S_CAP_PREV = 4'd4,
      S_OFFER    = 4'd5,
      S_WAIT_RES = 4'd6,
      S_WRITE    = 4'd7,
      S_ROTATE   = 4'd8,
      S_HOST_RD  = 4'd9,
      S_HOST_ACK = 4'd10
   } state_t;

   localparam logic [1:0] ROLE_CUR  = 2'd0;
   localparam logic [1:0] ROLE_PREV = 2'd1;
   localparam logic [1:0] ROLE_NEXT = 2'd2;

   localparam logic [1:0] RST_CUR_P  = 2'd0;
   localparam logic [1:0] RST_PREV_P = 2'd1;
   localparam logic [1:0] RST_NEXT_P = 2'd2;

endpackage

// File: rtl/patch_role_map.sv
// Holds which physical patch plays cur/prev/next, rotates the roles on request,
// and translates a host role code into a physical patch index.
module patch_role_map
   import patch_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rotate_i,
   input  logic [1:0] role_i,
   output logic [1:0] cur_p_o,
   output logic [1:0] prev_p_o,
   output logic [1:0] next_p_o,
   output logic [1:0] patch_o
);

   logic [1:0] cur_q;
   logic [1:0] prev_q;
   logic [1:0] next_q;

   // The freshly written patch becomes current; the oldest one is reused for writing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q  <= RST_CUR_P;
         prev_q <= RST_PREV_P;
         next_q <= RST_NEXT_P;
      end else if (rotate_i) begin
         cur_q  <= next_q;
         prev_q <= cur_q;
         next_q <= prev_q;
      end
   end

   always_comb begin
      patch_o = cur_q;
      case (role_i)
         ROLE_PREV: patch_o = prev_q;
         ROLE_NEXT: patch_o = next_q;
         default:   patch_o = cur_q;
      endcase
   end

   assign cur_p_o  = cur_q;
   assign prev_p_o = prev_q;
   assign next_p_o = next_q;

endmodule

// File: rtl/patch_step_scheduler.sv
// Time-step sequencer for the three-patch node memory: per-node read, operand
// offer, result write-back, role rotation at step end, host access between steps.
module patch_step_scheduler
   import patch_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_patch,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              upd_valid,
   input  logic              upd_ready,
   output logic [ADDR_W-1:0] upd_node,
   output logic [DATA_W-1:0] upd_cur,
   output logic [DATA_W-1:0] upd_prev,
   input  logic              res_valid,
   input  logic [DATA_W-1:0] res_data,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [1:0]        host_role,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic [3:0]        dbg_state
);

   state_t              state_q;
   logic [ADDR_W-1:0]   node_q;
   logic                busy_q;
   logic                done_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [1:0]          mem_patch_q;
   logic                mem_we_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic                upd_valid_q;
   logic [DATA_W-1:0]   upd_cur_q;
   logic [DATA_W-1:0]   upd_prev_q;
   logic                host_ack_q;
   logic [DATA_W-1:0]   host_rdata_q;
   logic                host_rd_q;

   logic                rotate_d;
   logic [1:0]          cur_p;
   logic [1:0]          prev_p;
   logic [1:0]          next_p;
   logic [1:0]          host_patch;

   assign rotate_d = (state_q == S_ROTATE);

   patch_role_map u_role_map (
      .clk      (clk),
      .rst_n    (rst_n),
      .rotate_i (rotate_d),
      .role_i   (host_role),
      .cur_p_o  (cur_p),
      .prev_p_o (prev_p),
      .next_p_o (next_p),
      .patch_o  (host_patch)
   );

   // Update-unit handshake: an operand transfer happens on a rising edge where
   // upd_valid && upd_ready; upd_valid, upd_node, upd_cur and upd_prev are held
   // until then. res_valid is only sampled in WAIT_RES and is never backpressured.
   // Memory reads are registered: an address set on leaving a state is seen by the
   // memory in the following state and its data is captured one state later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         node_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         mem_addr_q   <= '0;
         mem_patch_q  <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         upd_valid_q  <= 1'b0;
         upd_cur_q    <= '0;
         upd_prev_q   <= '0;
         host_ack_q   <= 1'b0;
         host_rdata_q <= '0;
         host_rd_q    <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         host_ack_q <= 1'b0;
         mem_we_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  busy_q  <= 1'b1;
                  node_q  <= '0;
                  state_q <= S_RD_CUR;
               end else if (host_req) begin
                  mem_addr_q  <= host_addr;
                  mem_patch_q <= host_patch;
                  host_rd_q   <= !host_we;
                  if (host_we) begin
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= host_wdata;
                     state_q     <= S_HOST_ACK;
                  end else begin
                     state_q <= S_HOST_RD;
                  end
               end
            end
            S_RD_CUR: begin
               mem_addr_q  <= node_q;
               mem_patch_q <= cur_p;
               state_q     <= S_RD_PREV;
            end
            S_RD_PREV: begin
               mem_patch_q <= prev_p;
               state_q     <= S_CAP_CUR;
            end
            S_CAP_CUR: begin
               upd_cur_q <= mem_rdata;
               state_q   <= S_CAP_PREV;
            end
            S_CAP_PREV: begin
               upd_prev_q  <= mem_rdata;
               upd_valid_q <= 1'b1;
               state_q     <= S_OFFER;
            end
            S_OFFER: begin
               if (upd_ready) begin
                  upd_valid_q <= 1'b0;
                  state_q     <= S_WAIT_RES;
               end
            end
            S_WAIT_RES: begin
               if (res_valid) begin
                  mem_we_q    <= 1'b1;
                  mem_patch_q <= next_p;
                  mem_addr_q  <= node_q;
                  mem_wdata_q <= res_data;
                  state_q     <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (node_q == ADDR_W'(PATCH_SIZE - 1)) begin
                  state_q <= S_ROTATE;
               end else begin
                  node_q  <= node_q + 1'b1;
                  state_q <= S_RD_CUR;
               end
            end
            S_ROTATE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               node_q  <= '0;
               state_q <= S_IDLE;
            end
            S_HOST_RD: begin
               state_q <= S_HOST_ACK;
            end
            S_HOST_ACK: begin
               host_ack_q <= 1'b1;
               if (host_rd_q) host_rdata_q <= mem_rdata;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign mem_addr   = mem_addr_q;
   assign mem_patch  = mem_patch_q;
   assign mem_we     = mem_we_q;
   assign mem_wdata  = mem_wdata_q;
   assign upd_valid  = upd_valid_q;
   assign upd_node   = node_q;
   assign upd_cur    = upd_cur_q;
   assign upd_prev   = upd_prev_q;
   assign host_ack   = host_ack_q;
   assign host_rdata = host_rdata_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_patch_step_scheduler.sv
// Bench for patch_step_scheduler: memory model, echo update unit, role-level
// reference of the three patches, scenario tasks and a final report.
module tb_patch_step_scheduler;
   import patch_sched_pkg::*;

   localparam int W  = DATA_W;
   localparam int OW = ADDR_W + 2 * DATA_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic              start = 1'b0;
   logic              busy, done;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_patch;
   logic              mem_we;
   logic [W-1:0]      mem_wdata;
   logic [W-1:0]      mem_rdata = '0;
   logic              upd_valid;
   logic              upd_ready = 1'b1;
   logic [ADDR_W-1:0] upd_node;
   logic [W-1:0]      upd_cur, upd_prev;
   logic              res_valid = 1'b0;
   logic [W-1:0]      res_data = '0;
   logic              host_req = 1'b0;
   logic              host_we = 1'b0;
   logic [1:0]        host_role = '0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [W-1:0]      host_wdata = '0;
   logic              host_ack;
   logic [W-1:0]      host_rdata;
   logic [3:0]        dbg_state;

   patch_step_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_patch(mem_patch), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_node(upd_node),
      .upd_cur(upd_cur), .upd_prev(upd_prev),
      .res_valid(res_valid), .res_data(res_data),
      .host_req(host_req), .host_we(host_we), .host_role(host_role),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata), .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- memory model (single port, registered read) ----------------
   logic signed [W-1:0] mem [0:47];
   int wr_cnt = 0;
   int bad_patch = 0;

   always @(posedge clk) begin
      if (mem_patch > 2'd2) begin
         bad_patch <= bad_patch + 1;
      end else begin
         mem_rdata <= mem[int'(mem_patch) * 16 + int'(mem_addr)];
         if (mem_we) begin
            mem[int'(mem_patch) * 16 + int'(mem_addr)] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
         end
      end
   end

   // ---------------- reference model: patches by physical index, roles as ints ----------------
   logic signed [W-1:0] ref_p [3][16];
   int r_cur = 0, r_prev = 1, r_next = 2;

   function automatic int role_patch(input int role);
      case (role)
         1: return r_prev;
         2: return r_next;
         default: return r_cur;
      endcase
   endfunction

   function automatic void ref_compute(input int nodes);
      for (int n = 0; n < nodes; n++) ref_p[r_next][n] = ref_p[r_cur][n] + ref_p[r_prev][n];
   endfunction

   function automatic void ref_rotate();
      int c, p, x;
      c = r_cur; p = r_prev; x = r_next;
      r_cur = x; r_prev = c; r_next = p;
   endfunction

   // ---------------- scoreboard of expected operand offers ----------------
   logic [OW-1:0] exp_q[$];

   // ---------------- update unit: echo cur+prev one cycle after accept ----------------
   int            stall_node = -1;
   int            stall_left = 0;
   bit            pending = 1'b0;
   logic [W-1:0]  pend_data;
   bit            held_ok = 1'b0;
   logic [OW-1:0] held;

   always @(negedge clk) begin
      logic [OW-1:0] obs, e;
      res_valid = 1'b0;
      if (!rst_n) begin
         pending = 1'b0;
         held_ok = 1'b0;
         upd_ready = 1'b1;
      end else begin
         if (pending) begin
            res_valid = 1'b1;
            res_data  = pend_data;
            pending   = 1'b0;
         end
         if (upd_valid) begin
            obs = {upd_node, upd_cur, upd_prev};
            if (!held_ok) begin
               held = obs;
               held_ok = 1'b1;
            end else begin
               checks++;
               if (obs !== held) begin
                  errors++;
                  $display("FAIL offer_stable got %0h exp %0h", obs, held);
               end
            end
            if (stall_left > 0 && int'(upd_node) == stall_node) begin
               upd_ready = 1'b0;
               stall_left--;
               if (stall_left == 2) begin
                  res_valid = 1'b1;
                  res_data  = 18'h2AAAA;
               end
            end else begin
               upd_ready = 1'b1;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL offer_unexpected got %0h exp none", obs);
               end else begin
                  e = exp_q.pop_front();
                  if (obs !== e) begin
                     errors++;
                     $display("FAIL offer_operands got %0h exp %0h", obs, e);
                  end
               end
               pending   = 1'b1;
               pend_data = upd_cur + upd_prev;
               held_ok   = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic host_op(input bit we, input int role, input int addr,
                          input logic [W-1:0] wd, output logic [W-1:0] rd,
                          output bit ok, output longint t_ack);
      @(negedge clk);
      host_req = 1'b1; host_we = we; host_role = 2'(role);
      host_addr = ADDR_W'(addr); host_wdata = wd;
      ok = 1'b0; rd = '0; t_ack = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (host_ack) begin
            ok = 1'b1; rd = host_rdata; t_ack = $time;
            break;
         end
      end
      host_req = 1'b0;
   endtask

   task automatic host_write_ref(input int role, input int addr, input logic [W-1:0] wd, output bit ok);
      logic [W-1:0] rd;
      longint t;
      host_op(1'b1, role, addr, wd, rd, ok, t);
      ref_p[role_patch(role)][addr] = wd;
   endtask

   // Runs one step with the echo unit; cyc is start-accept edge to done edge.
   task automatic run_step(input int mid_pulse, output int cyc, output longint t_done,
                           output bit ack_early, output bit busy1);
      for (int n = 0; n < 16; n++)
         exp_q.push_back({ADDR_W'(n), ref_p[r_cur][n], ref_p[r_prev][n]});
      cyc = -1; t_done = 0; ack_early = 1'b0; busy1 = 1'b0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 1; c <= 1500; c++) begin
         @(negedge clk);
         if (c == 1) busy1 = busy;
         start = (c == mid_pulse);
         if (host_ack) ack_early = 1'b1;
         if (done) begin
            cyc = c - 1; t_done = $time;
            break;
         end
      end
      start = 1'b0;
      ref_compute(16);
      ref_rotate();
   endtask

   task automatic check_mem(input string name);
      int bad = 0;
      int first = -1;
      for (int p = 0; p < 3; p++)
         for (int n = 0; n < 16; n++)
            if (mem[p * 16 + n] !== ref_p[p][n]) begin
               bad++;
               if (first < 0) first = p * 16 + n;
            end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s mem[%0d] got %0d exp %0d (%0d entries differ)",
                  name, first, mem[first], ref_p[first / 16][first % 16], bad);
      end
   endtask

   task automatic check_int(input string name, input longint got, input longint expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", name, got, expv);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      logic [127:0] v;
      v = 128'({busy, done, mem_addr, mem_patch, mem_we, mem_wdata, upd_valid, upd_node,
                upd_cur, upd_prev, host_ack, host_rdata, dbg_state});
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL %s got %0h exp 0", name, v);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_outputs");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_outputs_zero("idle_after_reset");
   endtask

   task automatic test_host_access();
      logic [W-1:0] rd;
      bit ok, all_ok;
      longint t;
      host_write_ref(0, 5, 18'sd1000, ok);
      check_int("host_wr0_ack", ok, 1);
      host_write_ref(1, 5, -18'sd7, ok);
      check_int("host_wr1_ack", ok, 1);
      host_op(1'b0, 0, 5, '0, rd, ok, t);
      check_int("host_rd0_ack", ok, 1);
      check_int("host_rd0_data", $signed(rd), 1000);
      host_op(1'b0, 1, 5, '0, rd, ok, t);
      check_int("host_rd1_data", $signed(rd), -7);
      check_int("mem_patch0_5", $signed(mem[5]), 1000);
      check_int("mem_patch1_5", $signed(mem[21]), -7);
      // role code 3 aliases the current patch
      host_write_ref(3, 6, 18'sd4321, ok);
      check_int("mem_role3_is_cur", $signed(mem[6]), 4321);
      all_ok = 1'b1;
      for (int r = 0; r < 3; r++)
         for (int n = 0; n < 16; n++) begin
            host_write_ref(r, n, W'($urandom_range(0, (1 << W) - 1)), ok);
            if (!ok) all_ok = 1'b0;
         end
      check_int("preload_acks", all_ok, 1);
      check_mem("preload_mem");
   endtask

   task automatic test_single_step();
      int cyc, w0;
      longint td;
      bit ae, b1;
      logic [W-1:0] rd;
      bit ok;
      longint t;
      int n;
      w0 = wr_cnt;
      run_step(-1, cyc, td, ae, b1);
      check_int("step1_busy", b1, 1);
      check_int("step1_cycles", cyc, 113);
      check_int("step1_writes", wr_cnt - w0, 16);
      check_int("step1_offers_left", exp_q.size(), 0);
      check_mem("step1_mem");
      @(negedge clk);
      check_int("step1_busy_cleared", busy, 0);
      n = $urandom_range(0, 15);
      host_op(1'b0, 0, n, '0, rd, ok, t);
      check_int("step1_cur_role_read", $signed(rd), $signed(ref_p[2][n]));
   endtask

   task automatic test_three_steps();
      int cyc, rl, n;
      longint td, t;
      bit ae, b1, ok;
      logic [W-1:0] rd;
      for (int s = 0; s < 3; s++) begin
         run_step(-1, cyc, td, ae, b1);
         check_int("steps_cycles", cyc, 113);
         check_mem("steps_mem");
         n = $urandom_range(0, 15);
         host_op(1'b0, 0, n, '0, rd, ok, t);
         check_int("steps_cur_read", $signed(rd), $signed(ref_p[r_cur][n]));
         rl = $urandom_range(1, 2);
         n = $urandom_range(0, 15);
         host_op(1'b0, rl, n, '0, rd, ok, t);
         check_int("steps_role_read", $signed(rd), $signed(ref_p[role_patch(rl)][n]));
      end
   endtask

   task automatic test_backpressure();
      int cyc, w0;
      longint td;
      bit ae, b1;
      stall_node = 3;
      stall_left = 5;
      w0 = wr_cnt;
      run_step(-1, cyc, td, ae, b1);
      check_int("bp_cycles", cyc, 118);
      check_int("bp_stall_used", stall_left, 0);
      check_int("bp_writes", wr_cnt - w0, 16);
      check_mem("bp_mem");
      stall_node = -1;
   endtask

   task automatic test_contention();
      int cyc, w0, n;
      longint td, ta;
      bit ae, b1, ok;
      logic [W-1:0] rd;
      n = $urandom_range(0, 15);
      w0 = wr_cnt;
      fork
         run_step(50, cyc, td, ae, b1);
         host_op(1'b0, 0, n, '0, rd, ok, ta);
      join
      check_int("cont_cycles", cyc, 113);
      check_int("cont_no_early_ack", ae, 0);
      check_int("cont_ack", ok, 1);
      check_int("cont_ack_after_done", ta > td, 1);
      check_int("cont_rdata", $signed(rd), $signed(ref_p[r_cur][n]));
      check_int("cont_writes", wr_cnt - w0, 16);
      repeat (10) @(negedge clk);
      check_int("cont_no_restart", busy, 0);
      check_mem("cont_mem");
   endtask

   task automatic test_reset_mid_step();
      int w0, cyc;
      bit seen, saw_done, ae, b1;
      longint td;
      for (int k = 0; k < 16; k++)
         exp_q.push_back({ADDR_W'(k), ref_p[r_cur][k], ref_p[r_prev][k]});
      w0 = wr_cnt;
      seen = 1'b0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (wr_cnt - w0 == 8) begin
            seen = 1'b1;
            break;
         end
      end
      check_int("rst_mid_reached_node8", seen, 1);
      #1 rst_n = 1'b0;
      #1 check_outputs_zero("rst_mid_outputs");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      ref_compute(8);
      r_cur = 0; r_prev = 1; r_next = 2;
      saw_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      check_int("rst_mid_no_done", saw_done, 0);
      check_mem("rst_mid_partial_mem");
      run_step(-1, cyc, td, ae, b1);
      check_int("rst_mid_restart_cycles", cyc, 113);
      check_mem("rst_mid_restart_mem");
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_host_access();
      test_single_step();
      test_three_steps();
      test_backpressure();
      test_contention();
      test_reset_mid_step();
      check_int("patch_index_in_range", bad_patch, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
